// File: rtl/gcm_ctr_scheduler.sv
// Purpose: sequences AES-GCM beats (AAD, PT, length block) into the AES pipeline with counter blocks.
// Latency: issue is combinational with the accepted input beat; result tags emerge PIPE_LATENCY cycles later.
// Backpressure: issue stalls when no downstream result credit is left; o_data_ready drops combinationally.
module gcm_ctr_scheduler #(
    parameter int          PIPE_LATENCY = 10,
    parameter int          CREDITS      = 16,
    // Low 32 bits of the first counter block; 2 for a 96-bit IV, overridable to exercise inc32 wrap.
    parameter logic [31:0] CB_INIT_LO   = 32'h2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [95:0]  i_iv,
    input  logic [15:0]  i_aad_blocks,
    input  logic [15:0]  i_pt_blocks,
    input  logic         i_data_valid,
    input  logic [127:0] i_data,
    output logic         o_data_ready,
    input  logic         i_out_pop,
    output logic         o_busy,
    output logic         o_pipe_valid,
    output logic [127:0] o_pipe_plain_text,
    output logic [127:0] o_pipe_aad,
    output logic [127:0] o_pipe_cb,
    output logic [127:0] o_pipe_j0,
    output logic [127:0] o_pipe_instance_size,
    output logic         o_pipe_new_instance,
    output logic         o_result_valid,
    output logic [1:0]   o_result_kind,
    output logic         o_result_last
);

    localparam int CW = $clog2(CREDITS + 1);

    localparam logic [1:0] KIND_AAD = 2'd0;
    localparam logic [1:0] KIND_PT  = 2'd1;
    localparam logic [1:0] KIND_LEN = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AAD  = 2'd1,
        PT   = 2'd2,
        LEN  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_n;

    logic [95:0]     iv_q;
    logic [15:0]     aad_q;
    logic [15:0]     pt_q;
    logic [15:0]     aad_rem;
    logic [15:0]     pt_rem;
    logic [31:0]     cb_lo;
    logic            first_q;
    logic [CW-1:0]   credit;

    logic            has_credit;
    logic            issue;
    logic            ready;
    logic [1:0]      beat_kind;
    logic [127:0]    inst_size;

    // Result tag per stage: {valid, kind[1:0], last}; invalid stages hold all zeros.
    logic [3:0]      res_sr [PIPE_LATENCY];
    logic [3:0]      res_in;

    assign has_credit = (credit != '0);

    // Bit lengths of AAD and PT (blocks * 128), as used by the GHASH length block.
    assign inst_size = {41'h0, aad_q, 7'h0, 41'h0, pt_q, 7'h0};

    // Next-state and issue decision; an issue always consumes one credit.
    always_comb begin
        state_n   = state;
        issue     = 1'b0;
        ready     = 1'b0;
        beat_kind = KIND_AAD;
        case (state)
            IDLE: begin
                if (i_start) begin
                    if (i_aad_blocks != 16'd0) begin
                        state_n = AAD;
                    end else if (i_pt_blocks != 16'd0) begin
                        state_n = PT;
                    end else begin
                        state_n = LEN;
                    end
                end
            end
            AAD: begin
                ready     = has_credit;
                beat_kind = KIND_AAD;
                if (i_data_valid && has_credit) begin
                    issue = 1'b1;
                    if (aad_rem == 16'd1) begin
                        state_n = (pt_q != 16'd0) ? PT : LEN;
                    end
                end
            end
            PT: begin
                ready     = has_credit;
                beat_kind = KIND_PT;
                if (i_data_valid && has_credit) begin
                    issue = 1'b1;
                    if (pt_rem == 16'd1) begin
                        state_n = LEN;
                    end
                end
            end
            LEN: begin
                beat_kind = KIND_LEN;
                if (has_credit) begin
                    issue   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Instance context: latched on start, remaining-beat counters and inc32 counter advance on issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iv_q    <= '0;
            aad_q   <= '0;
            pt_q    <= '0;
            aad_rem <= '0;
            pt_rem  <= '0;
            cb_lo   <= '0;
            first_q <= 1'b0;
        end else if (state == IDLE) begin
            if (i_start) begin
                iv_q    <= i_iv;
                aad_q   <= i_aad_blocks;
                pt_q    <= i_pt_blocks;
                aad_rem <= i_aad_blocks;
                pt_rem  <= i_pt_blocks;
                cb_lo   <= CB_INIT_LO;
                first_q <= 1'b1;
            end
        end else if (issue) begin
            first_q <= 1'b0;
            if (state == AAD) begin
                aad_rem <= aad_rem - 16'd1;
            end
            if (state == PT) begin
                pt_rem <= pt_rem - 16'd1;
                cb_lo  <= cb_lo + 32'd1;
            end
        end
    end

    // Credit accounting: issue takes a slot, pop returns one, both together cancel; saturates at CREDITS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= CW'(CREDITS);
        end else if (issue && !i_out_pop) begin
            credit <= credit - CW'(1);
        end else if (!issue && i_out_pop && (credit < CW'(CREDITS))) begin
            credit <= credit + CW'(1);
        end
    end

    assign res_in = {issue, (issue ? beat_kind : 2'd0), (issue && (beat_kind == KIND_LEN))};

    // Tag shift register modelling the AES pipeline depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                res_sr[i] <= 4'h0;
            end
        end else begin
            res_sr[0] <= res_in;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                res_sr[i] <= res_sr[i-1];
            end
        end
    end

    assign o_busy               = (state != IDLE);
    assign o_data_ready         = ready;
    assign o_pipe_valid         = issue;
    assign o_pipe_plain_text    = (issue && (state == PT)) ? i_data : 128'h0;
    assign o_pipe_aad           = (issue && (state == AAD)) ? i_data :
                                  (issue && (state == LEN)) ? inst_size : 128'h0;
    assign o_pipe_cb            = issue ? {iv_q, cb_lo} : 128'h0;
    assign o_pipe_j0            = issue ? {iv_q, 32'h1} : 128'h0;
    assign o_pipe_instance_size = issue ? inst_size : 128'h0;
    assign o_pipe_new_instance  = issue && first_q;

    assign o_result_valid = res_sr[PIPE_LATENCY-1][3];
    assign o_result_kind  = res_sr[PIPE_LATENCY-1][2:1];
    assign o_result_last  = res_sr[PIPE_LATENCY-1][0];

endmodule
